// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline skid buffer: FSM state codes and width.
package pipeline_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/register.sv
// Generic enabled register with synchronous active-high reset to a fixed value.
module register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (rst)
            data_out <= RESET_VALUE;
        else if (enable)
            data_out <= data_in;
    end

endmodule

// File: rtl/pipeline_skid_buffer.sv
// Two-entry ready/valid skid buffer: output register plus skid register, steered
// by a 3-state FSM so both handshake directions are fully registered.
module pipeline_skid_buffer
    import pipeline_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [WIDTH-1:0] input_data,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [WIDTH-1:0] output_data
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [WIDTH-1:0]   skid_q;
    logic [WIDTH-1:0]   out_d;
    logic               load_out;
    logic               load_skid;
    logic               insert;
    logic               remove;
    logic               ready_d;
    logic               valid_d;

    assign insert = input_valid & input_ready;
    assign remove = output_valid & output_ready;

    always_comb begin
        state_d   = ST_EMPTY;
        load_out  = 1'b0;
        load_skid = 1'b0;
        out_d     = input_data;
        case (state_t'(state_q))
            ST_EMPTY: begin
                state_d  = insert ? ST_BUSY : ST_EMPTY;
                load_out = insert;
            end
            ST_BUSY: begin
                if (insert && !remove) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (insert && remove) begin
                    state_d  = ST_BUSY;
                    load_out = 1'b1;
                end else if (remove) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_FULL: begin
                // Skid word moves forward so it leaves before anything newer.
                out_d = skid_q;
                if (remove) begin
                    state_d  = ST_BUSY;
                    load_out = 1'b1;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Handshake outputs are flops fed from the next state, so no comb path crosses.
    assign ready_d = (state_d != ST_FULL);
    assign valid_d = (state_d != ST_EMPTY);

    register #(.WIDTH(STATE_W), .RESET_VALUE(ST_EMPTY)) u_state (
        .clk(clk), .rst(rst), .enable(1'b1), .data_in(state_d), .data_out(state_q)
    );

    register #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_out (
        .clk(clk), .rst(rst), .enable(load_out), .data_in(out_d), .data_out(output_data)
    );

    register #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
        .clk(clk), .rst(rst), .enable(load_skid), .data_in(input_data), .data_out(skid_q)
    );

    register #(.WIDTH(1), .RESET_VALUE(1'b1)) u_ready (
        .clk(clk), .rst(rst), .enable(1'b1), .data_in(ready_d), .data_out(input_ready)
    );

    register #(.WIDTH(1), .RESET_VALUE(1'b0)) u_valid (
        .clk(clk), .rst(rst), .enable(1'b1), .data_in(valid_d), .data_out(output_valid)
    );

endmodule
